mux4_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 4:1 byte-wide mux datapath between four requesters (A–D).
- Drives the mux select and accepts beats from the granted requester.
- Delivers beats through a registered valid/ready output stage.
- Sits in front of any shared downstream consumer that previously took a statically selected mux output.

---
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between requesters A..D.
// The granted owner streams beats into a registered valid/ready output
// stage. An owner is bounded to MAX_BURST consecutive beats while another
// requester waits, and each owner change costs one idle arbitration cycle.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt, select_nxt, winner;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic [3:0]       owner_mask, others;
  logic             can_load, load;
  logic [WIDTH-1:0] mux_data;

  // First set request bit searching ptr, ptr+1, ... with 2-bit wrap.
  // Walking downward and overwriting leaves the nearest hit as the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner     = rr_pick(req, ptr);
  assign owner_mask = 4'b0001 << select;
  assign others     = req & ~owner_mask;
  assign can_load   = !out_valid || out_ready;
  assign busy       = (state == GRANT);

  // Shared 4:1 datapath steered by the registered owner.
  always_comb begin
    mux_data = data_a;
    case (select)
      2'd0: mux_data = data_a;
      2'd1: mux_data = data_b;
      2'd2: mux_data = data_c;
      2'd3: mux_data = data_d;
      default: mux_data = data_a;
    endcase
  end

  // Arbitration, beat acceptance and burst limiting.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    select_nxt = select;
    burst_nxt  = burst_cnt;
    gnt        = 4'b0000;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          select_nxt = winner;
          burst_nxt  = '0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (req[select]) begin
          if (can_load) begin
            gnt  = owner_mask;
            load = 1'b1;
            if (burst_cnt == LAST_BEAT) begin
              // Yield only when someone else is actually waiting.
              burst_nxt = '0;
              if (|others) begin
                state_nxt = IDLE;
                ptr_nxt   = select + 2'd1;
              end
            end else begin
              burst_nxt = burst_cnt + CNT_W'(1);
            end
          end
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = select + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      gnt  = 4'b0000;
      load = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      select    <= 2'd0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      select    <= select_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Output register stage: load wins, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
